// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron step scheduler: FSM state encoding and
// default sizing constants used by the scheduler and its interval counter.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } step_state_t;

    localparam int DEFAULT_NUM_AXONS      = 2;
    localparam int DEFAULT_STEP_INTERVAL  = 32;
    localparam int DEFAULT_STEP_CNT_WIDTH = 16;
    // Wide enough for the largest legal interval (2^16-1 cycles).
    localparam int INTERVAL_CNT_WIDTH     = 16;

endpackage

// File: rtl/step_interval_counter.sv
// Saturating cycle counter for one step interval: synchronous clear back to
// zero, counts up and holds at TERMINAL, flags when the terminal value is reached.
module step_interval_counter
    import neuron_pkg::*;
#(
    parameter int TERMINAL = DEFAULT_STEP_INTERVAL - 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic at_terminal
);

    localparam logic [INTERVAL_CNT_WIDTH-1:0] TERM = INTERVAL_CNT_WIDTH'(TERMINAL);

    logic [INTERVAL_CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != TERM) begin
            count <= count + INTERVAL_CNT_WIDTH'(1);
        end
    end

    assign at_terminal = (count == TERM);

endmodule

// File: rtl/neuron_step_scheduler.sv
// Fixed-period step scheduler for a neuron core: issues start pulses every
// STEP_INTERVAL cycles and latches axon spikes per step. Optional macro
// NEURON_STDP_WINDOW_EN adds the post_spike_seen output for STDP.
module neuron_step_scheduler
    import neuron_pkg::*;
#(
    parameter int NUM_AXONS      = DEFAULT_NUM_AXONS,
    parameter int STEP_INTERVAL  = DEFAULT_STEP_INTERVAL,
    parameter int NUM_STEPS      = 0,
    parameter int STEP_CNT_WIDTH = DEFAULT_STEP_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      neuron_done,
    input  logic [NUM_AXONS-1:0]      axon_spike,
    input  logic                      outSpike,
    output logic                      start,
    output logic [NUM_AXONS-1:0]      inSpike,
    output logic [STEP_CNT_WIDTH-1:0] step_cnt,
    output logic                      busy,
    output logic                      run_done,
    output logic                      overrun
`ifdef NEURON_STDP_WINDOW_EN
    ,
    output logic                      post_spike_seen
`endif
);

    localparam bit                        LIMITED   = (NUM_STEPS != 0);
    localparam logic [STEP_CNT_WIDTH-1:0] STEP_LIMIT = STEP_CNT_WIDTH'(NUM_STEPS);

    step_state_t               state;
    step_state_t               next_state;
    logic                      clear_interval;
    logic                      interval_tc;
    logic                      done_accept;
    logic                      late_done;
    logic                      limit_at_done;
    logic [STEP_CNT_WIDTH-1:0] step_cnt_next;

    step_interval_counter #(
        .TERMINAL (STEP_INTERVAL - 1)
    ) u_interval (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear_interval),
        .at_terminal (interval_tc)
    );

    assign step_cnt_next = step_cnt + STEP_CNT_WIDTH'(1);
    assign limit_at_done = LIMITED && (step_cnt_next == STEP_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A done that lands on an expired interval restarts immediately instead of
    // passing through GAP, so the late step does not cost a further period.
    always_comb begin
        next_state  = state;
        done_accept = 1'b0;
        late_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && !run_done) next_state = ST_START;
            end
            ST_START: begin
                next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (neuron_done) begin
                    done_accept = 1'b1;
                    if (interval_tc) begin
                        late_done  = 1'b1;
                        next_state = (enable && !limit_at_done) ? ST_START : ST_IDLE;
                    end else begin
                        next_state = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (interval_tc) next_state = (enable && !run_done) ? ST_START : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        // Zero on entry to START so START is cycle 0 of the interval.
        clear_interval = (next_state == ST_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
            run_done <= 1'b0;
            overrun  <= 1'b0;
            inSpike  <= '0;
        end else begin
            if (done_accept) begin
                step_cnt <= step_cnt_next;
                if (limit_at_done) run_done <= 1'b1;
                if (late_done)     overrun  <= 1'b1;
            end
            if (state == ST_START) inSpike <= axon_spike;
        end
    end

    assign start = (state == ST_START);
    assign busy  = (state != ST_IDLE);

`ifdef NEURON_STDP_WINDOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_spike_seen <= 1'b0;
        end else if (state == ST_START) begin
            post_spike_seen <= 1'b0;
        end else if (state == ST_WAIT_DONE && outSpike) begin
            post_spike_seen <= 1'b1;
        end
    end
`else
    // Output spike only matters to the STDP window.
    logic unused_out_spike;
    assign unused_out_spike = outSpike;
`endif

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Scoreboard bench: dut_a free-running, dut_b limited to 5 steps; expected
// start cycles and step counts are queued when neuron_done is driven.
module tb_neuron_step_scheduler;

    localparam int SI = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_a, done_a, out_spike_a;
    logic [1:0]  axon_a;
    logic        start_a, busy_a, run_done_a, overrun_a;
    logic [1:0]  in_spike_a;
    logic [15:0] step_cnt_a;
    logic        enable_b, done_b, out_spike_b;
    logic [1:0]  axon_b;
    logic        start_b, busy_b, run_done_b, overrun_b;
    logic [1:0]  in_spike_b;
    logic [15:0] step_cnt_b;
`ifdef NEURON_STDP_WINDOW_EN
    logic        pss_a, pss_b;
`endif

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   starts_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_step_scheduler #(
        .NUM_AXONS(2), .STEP_INTERVAL(SI), .NUM_STEPS(0), .STEP_CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a), .neuron_done(done_a),
        .axon_spike(axon_a), .outSpike(out_spike_a), .start(start_a),
        .inSpike(in_spike_a), .step_cnt(step_cnt_a), .busy(busy_a),
`ifdef NEURON_STDP_WINDOW_EN
        .post_spike_seen(pss_a),
`endif
        .run_done(run_done_a), .overrun(overrun_a)
    );

    neuron_step_scheduler #(
        .NUM_AXONS(2), .STEP_INTERVAL(SI), .NUM_STEPS(5), .STEP_CNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b), .neuron_done(done_b),
        .axon_spike(axon_b), .outSpike(out_spike_b), .start(start_b),
        .inSpike(in_spike_b), .step_cnt(step_cnt_b), .busy(busy_b),
`ifdef NEURON_STDP_WINDOW_EN
        .post_spike_seen(pss_b),
`endif
        .run_done(run_done_b), .overrun(overrun_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each observed start pops the oldest expectation; a start with nothing queued is spurious.
    always @(posedge clk) begin
        #1;
        if (start_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check_eq("a_spurious_start", 1, 0);
            end else begin
                e_a = q_a.pop_front();
                check_eq("a_start_cycle", cyc, e_a.cyc);
                check_eq("a_step_cnt_at_start", step_cnt_a, e_a.cnt);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (start_b === 1'b1) begin
            starts_b++;
            if (q_b.size() == 0) begin
                check_eq("b_spurious_start", 1, 0);
            end else begin
                e_b = q_b.pop_front();
                check_eq("b_start_cycle", cyc, e_b.cyc);
                check_eq("b_step_cnt_at_start", step_cnt_b, e_b.cnt);
            end
        end
    end

    task automatic wait_start(input bit sel_b, output int s);
        int n = 0;
        while ((sel_b ? start_b : start_a) !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if ((sel_b ? start_b : start_a) !== 1'b1) check_eq(sel_b ? "b_start_timeout" : "a_start_timeout", 0, 1);
        s = cyc;
    endtask

    // Neuron model: pulse done lat cycles after the start seen at cycle s.
    task automatic do_step(input bit sel_b, input int s, input int lat, input int k, input bit cont);
        exp_t ex;
        while (cyc < s + lat) tick();
        if (cont) begin
            ex.cyc = (lat >= SI - 1) ? s + lat + 1 : s + SI;
            ex.cnt = k + 1;
            if (sel_b) q_b.push_back(ex);
            else       q_a.push_back(ex);
        end
        if (sel_b) done_b = 1'b1;
        else       done_a = 1'b1;
        tick();
        done_a = 1'b0;
        done_b = 1'b0;
        check_eq(sel_b ? "b_cnt_after_done" : "a_cnt_after_done", sel_b ? step_cnt_b : step_cnt_a, k + 1);
    endtask

    task automatic push_a(input int c, input int n);
        exp_t ex;
        ex.cyc = c;
        ex.cnt = n;
        q_a.push_back(ex);
    endtask

    task automatic check_a_zero(input string tag);
        check_eq({tag, "_start"},    start_a,    0);
        check_eq({tag, "_inspike"},  in_spike_a, 0);
        check_eq({tag, "_step_cnt"}, step_cnt_a, 0);
        check_eq({tag, "_busy"},     busy_a,     0);
        check_eq({tag, "_run_done"}, run_done_a, 0);
        check_eq({tag, "_overrun"},  overrun_a,  0);
    endtask

    initial begin
        int s;
        exp_t ex;
        rst_n = 1'b0;
        enable_a = 1'b0; done_a = 1'b0; out_spike_a = 1'b0; axon_a = 2'b01;
        enable_b = 1'b0; done_b = 1'b0; out_spike_b = 1'b0; axon_b = 2'b11;
        repeat (3) tick();
        check_a_zero("rst");
        check_eq("rst_b_busy", busy_b, 0);

        // free-running, 10-cycle neuron, spike capture and ignored dones
        push_a(cyc + 1, 0);
        rst_n = 1'b1;
        enable_a = 1'b1;
        wait_start(1'b0, s);
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        check_eq("a_done_in_start_ignored", step_cnt_a, 0);
        check_eq("a_inspike_captured", in_spike_a, 2'b01);
        tick();
        axon_a = 2'b10;
        do_step(1'b0, s, 10, 0, 1'b1);
        while (cyc < s + 15) tick();
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        check_eq("a_done_in_gap_ignored", step_cnt_a, 1);
        while (cyc < s + 20) tick();
        check_eq("a_inspike_held", in_spike_a, 2'b01);
        wait_start(1'b0, s);
        check_eq("a_inspike_held_in_start", in_spike_a, 2'b01);
        tick();
        check_eq("a_inspike_next_step", in_spike_a, 2'b10);
        do_step(1'b0, s, 10, 1, 1'b1);
        wait_start(1'b0, s);
        do_step(1'b0, s, 10, 2, 1'b1);
        check_eq("a_no_overrun_yet", overrun_a, 0);

        // late done: overrun and restart on the cycle after done
        wait_start(1'b0, s);
        do_step(1'b0, s, 40, 3, 1'b1);
        check_eq("a_overrun_set", overrun_a, 1);
        check_eq("a_start_after_late_done", start_a, 1);

        // enable dropped mid-step: step completes, then idle
        s = cyc;
        while (cyc < s + 5) tick();
        enable_a = 1'b0;
        do_step(1'b0, s, 10, 4, 1'b0);
        while (cyc < s + SI + 1) tick();
        check_eq("a_idle_after_disable", busy_a, 0);
        check_eq("a_cnt_after_disable", step_cnt_a, 5);
        repeat (40) tick();
        check_eq("a_still_idle", busy_a, 0);

        // reset in WAIT_DONE, then clean restart
        push_a(cyc + 1, 5);
        enable_a = 1'b1;
        wait_start(1'b0, s);
        while (cyc < s + 3) tick();
        check_eq("a_busy_before_reset", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check_a_zero("async_rst");
        tick();
        tick();
        check_eq("a_held_in_reset", busy_a, 0);
        push_a(cyc + 1, 0);
        rst_n = 1'b1;
        wait_start(1'b0, s);
        do_step(1'b0, s, 10, 0, 1'b1);
        wait_start(1'b0, s);
        enable_a = 1'b0;
        do_step(1'b0, s, 10, 1, 1'b0);
        while (cyc < s + SI + 1) tick();
        check_eq("a_final_idle", busy_a, 0);

        // limited run of 5 steps with enable held high
        ex.cyc = cyc + 1;
        ex.cnt = 0;
        q_b.push_back(ex);
        enable_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_start(1'b1, s);
            do_step(1'b1, s, 10, k, k < 4);
        end
        check_eq("b_run_done_at_last_done", run_done_b, 1);
        while (cyc < s + SI + 1) tick();
        check_eq("b_idle_after_run", busy_b, 0);
        check_eq("b_run_done_sticky", run_done_b, 1);
        check_eq("b_step_cnt_final", step_cnt_b, 5);
        repeat (80) tick();
        check_eq("b_start_count", starts_b, 5);
        check_eq("b_still_idle", busy_b, 0);
        check_eq("b_no_overrun", overrun_b, 0);
        check_eq("a_queue_drained", q_a.size(), 0);
        check_eq("b_queue_drained", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_step_scheduler.md
NEURON_STEP_SCHEDULER -- requirements
Module: neuron_step_scheduler

Interface
REQ-001 SHALL have parameter NUM_AXONS, default 2, width of the axon spike vector.
REQ-002 SHALL have parameter STEP_INTERVAL, default 32, cycles from one start pulse to the next; legal range 2..2^16-1.
REQ-003 SHALL have parameter NUM_STEPS, default 0, steps per run; 0 means free-running.
REQ-004 SHALL have parameter STEP_CNT_WIDTH, default 16, width of the step counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, a level that requests stepping.
REQ-008 SHALL have port neuron_done, input, 1, a one-cycle pulse from Neuron marking step completion.
REQ-009 SHALL have port axon_spike, input, NUM_AXONS, raw spike vector from the axon buffer.
REQ-010 SHALL have port outSpike, input, 1, neuron output spike.
REQ-011 SHALL have port start, output, 1, a one-cycle step-start pulse to Neuron.
REQ-012 SHALL have port inSpike, output, NUM_AXONS, spike vector held stable for the whole step.
REQ-013 SHALL have port step_cnt, output, STEP_CNT_WIDTH, the number of completed steps.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port run_done, output, 1, sticky, high after NUM_STEPS steps.
REQ-016 SHALL have port overrun, output, 1, sticky, set when neuron_done arrives after the interval has expired.

Function
REQ-017 SHALL implement the FSM IDLE, START, WAIT_DONE, GAP.
REQ-018 SHALL move IDLE->START when enable=1 and run_done=0.
REQ-019 SHALL spend exactly one cycle in START with start=1, capture axon_spike into inSpike on that edge, clear the interval counter, and go to WAIT_DONE.
REQ-020 SHALL count cycles in the interval counter from START; the counter saturates at STEP_INTERVAL-1.
REQ-021 SHALL, on neuron_done in WAIT_DONE, increment step_cnt (wrapping modulo 2^STEP_CNT_WIDTH) and go to GAP.
REQ-022 SHALL leave GAP when the interval counter equals STEP_INTERVAL-1, making the start-to-start period exactly STEP_INTERVAL cycles.
REQ-023 SHALL, when neuron_done arrives with the counter already at STEP_INTERVAL-1, set overrun and go directly to START if continuing.
REQ-024 SHALL, on leaving GAP or handling a late done, go to START if enable=1 and the step limit is not reached, otherwise go to IDLE.
REQ-025 SHALL, with enable deasserted mid-step, finish the current step and then enter IDLE; no step is aborted.
REQ-026 SHALL, with NUM_STEPS>0, set run_done and enter IDLE when step_cnt reaches NUM_STEPS; run_done clears only on reset.
REQ-027 SHALL ignore neuron_done outside WAIT_DONE.
REQ-028 SHALL ignore neuron_done in the START cycle.
REQ-029 SHALL hold inSpike constant outside START.

Reset
REQ-030 SHALL, with rst_n=0, immediately force state=IDLE and set start, inSpike, step_cnt, busy, run_done, overrun and the interval counter to 0.
REQ-031 SHALL, on reset mid-step, abandon the step with no start pulse on the deassertion edge.

Configuration
REQ-032 SHALL, with macro NEURON_STDP_WINDOW_EN defined, add output post_spike_seen (1 bit); it is set when outSpike=1 in WAIT_DONE, cleared in START, and readable for STDP during GAP.
REQ-033 SHALL, without NEURON_STDP_WINDOW_EN, omit the post_spike_seen port and its logic entirely.

Structure
REQ-034 SHALL keep the FSM state enum and the default interval/width constants in shared package neuron_pkg.
REQ-035 SHALL use one sub-module, step_interval_counter, which is the saturating interval counter with clear and terminal-count flag.

Verification
REQ-036 SHALL check: reset, enable=1, done 10 cycles after each start, STEP_INTERVAL=32 -> start pulses exactly 32 cycles apart, step_cnt increments by 1 per done.
REQ-037 SHALL check: NUM_STEPS=5, enable held high -> exactly 5 start pulses, run_done=1, busy=0, no further starts.
REQ-038 SHALL check: done 40 cycles after start, STEP_INTERVAL=32 -> overrun=1 and the next start on the cycle after done.
REQ-039 SHALL check: axon_spike=2'b01 at START, changed to 2'b10 mid-step -> inSpike stays 2'b01 until the next START.
REQ-040 SHALL check: enable dropped 5 cycles into a step -> the step completes, step_cnt increments, then IDLE with busy=0.
REQ-041 SHALL check: rst_n pulsed low in WAIT_DONE -> all outputs 0 immediately and a restart begins cleanly from IDLE.
